// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller: load-use stall, branch flush, data-memory wait freeze with timeout halt, event counters.
// Latency: control outputs are combinational (same cycle); state, mem_err and counters update on the next rising edge.
// Backpressure: a pending data-memory access freezes every stage register until dmem_ready; timeout halts until reset.
module pipeline_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             memr_idex,
    input  logic [4:0]       rd_idex,
    input  logic [31:0]      ir_ifid,
    input  logic             br_taken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mw_cnt,
    output logic [CNT_W-1:0] fl_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_nxt;
    logic       err_set;
    logic       is_lu, is_br, is_fz;

    logic [4:0] rs1, rs2;
    logic       lu_hit, frozen;
    logic       unused_ir;

    assign rs1       = ir_ifid[19:15];
    assign rs2       = ir_ifid[24:20];
    assign unused_ir = ^{ir_ifid[31:25], ir_ifid[14:0]};

    assign lu_hit = memr_idex && (rd_idex != 5'd0) && ((rd_idex == rs1) || (rd_idex == rs2));
    assign frozen = ((state == MEM_WAIT) && !dmem_ready) ||
                    ((state == RUN) && dmem_req && !dmem_ready);

    // Output priority: halt, freeze, branch flush, load-use, normal. Reset forces normal.
    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        is_lu      = 1'b0;
        is_br      = 1'b0;
        is_fz      = 1'b0;
        if (rst_n) begin
            if (state == HALT || frozen) begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                memwb_we = 1'b0;
                is_fz    = (state != HALT);
            end else if (br_taken_ex) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                is_br      = 1'b1;
            end else if (lu_hit) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                is_lu      = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        case (state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = HALT;
                    err_set   = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) mem_err <= 1'b1;
        end
    end

    // Saturating event counters; clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt <= '0;
            mw_cnt <= '0;
            fl_cnt <= '0;
        end else if (cnt_clr) begin
            lu_cnt <= '0;
            mw_cnt <= '0;
            fl_cnt <= '0;
        end else begin
            if (is_lu && lu_cnt != '1) lu_cnt <= lu_cnt + CNT_W'(1);
            if (is_fz && mw_cnt != '1) mw_cnt <= mw_cnt + CNT_W'(1);
            if (is_br && fl_cnt != '1) fl_cnt <= fl_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    localparam int C_N = 0, C_LU = 1, C_BR = 2, C_FZ = 3, C_HT = 4;

    typedef struct packed {
        logic [6:0]  ctrl;
        logic        err;
        logic [15:0] lu;
        logic [15:0] mw;
        logic [15:0] fl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memr_idex = 1'b0;
    logic [4:0]  rd_idex = 5'd0;
    logic [31:0] ir_ifid = 32'd0;
    logic        br_taken_ex = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush, mem_err;
    logic [15:0] lu_cnt, mw_cnt, fl_cnt;

    exp_t  exp_q[$];
    string name_q[$];
    logic  chk_vld = 1'b0;
    int    errors = 0;
    int    checks = 0;
    logic [15:0] e_lu = 16'd0, e_mw = 16'd0, e_fl = 16'd0;

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .memr_idex(memr_idex), .rd_idex(rd_idex),
        .ir_ifid(ir_ifid), .br_taken_ex(br_taken_ex), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .cnt_clr(cnt_clr), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mem_err(mem_err),
        .lu_cnt(lu_cnt), .mw_cnt(mw_cnt), .fl_cnt(fl_cnt)
    );

    always #5 clk = ~clk;

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
    function automatic logic [6:0] ctrl_of(input int cls);
        case (cls)
            C_LU:    return 7'b0011101;
            C_BR:    return 7'b1111111;
            C_FZ:    return 7'b0000000;
            C_HT:    return 7'b0000000;
            default: return 7'b1111100;
        endcase
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic step(input string nm, input bit chk, input logic rst, input logic mr,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic br, input logic dq, input logic dr, input logic clr,
                        input int cls, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n       = rst;
        memr_idex   = mr;
        rd_idex     = rd;
        ir_ifid     = {7'd0, r2, r1, 3'd0, 5'd0, 7'h03};
        br_taken_ex = br;
        dmem_req    = dq;
        dmem_ready  = dr;
        cnt_clr     = clr;
        if (!rst) begin
            e_lu = 16'd0;
            e_mw = 16'd0;
            e_fl = 16'd0;
        end
        if (chk) begin
            e = '{ctrl: ctrl_of(cls), err: err, lu: e_lu, mw: e_mw, fl: e_fl};
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        chk_vld = chk;
        if (rst) begin
            if (cls == C_LU) e_lu = sat_inc(e_lu);
            if (cls == C_FZ) e_mw = sat_inc(e_mw);
            if (cls == C_BR) e_fl = sat_inc(e_fl);
            if (clr) begin
                e_lu = 16'd0;
                e_mw = 16'd0;
                e_fl = 16'd0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_vld) begin
            exp_t  e;
            string nm;
            logic [6:0] act;
            act = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush};
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL scoreboard_underflow: got an output with no expectation queued, required one");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e.ctrl || mem_err !== e.err || lu_cnt !== e.lu ||
                    mw_cnt !== e.mw || fl_cnt !== e.fl) begin
                    errors = errors + 1;
                    $display("FAIL %s: got ctrl=%b err=%b lu=%h mw=%h fl=%h, required ctrl=%b err=%b lu=%h mw=%h fl=%h",
                             nm, act, mem_err, lu_cnt, mw_cnt, fl_cnt, e.ctrl, e.err, e.lu, e.mw, e.fl);
                end
            end
        end
    end

    initial begin
        //   name          chk rst mr rd  rs1 rs2 br dq dr clr class err
        step("reset_a",     1, 0, 1, 5,  5,  0,  1, 1, 0, 0, C_N,  0);
        step("reset_b",     1, 0, 1, 3,  0,  3,  0, 1, 0, 0, C_N,  0);
        step("normal",      1, 1, 0, 0,  0,  0,  0, 0, 0, 0, C_N,  0);
        step("lu_rs2",      1, 1, 1, 5,  0,  5,  0, 0, 0, 0, C_LU, 0);
        step("rd_zero",     1, 1, 1, 0,  0,  0,  0, 0, 0, 0, C_N,  0);
        step("lu_and_br",   1, 1, 1, 5,  5,  0,  1, 0, 0, 0, C_BR, 0);
        step("after_br",    1, 1, 0, 0,  1,  2,  0, 0, 0, 0, C_N,  0);
        step("lu_rs1",      1, 1, 1, 7,  7,  9,  0, 0, 0, 0, C_LU, 0);
        step("no_memread",  1, 1, 0, 7,  7,  7,  0, 0, 0, 0, C_N,  0);
        step("dmem_hit",    1, 1, 0, 0,  0,  0,  0, 1, 1, 0, C_N,  0);
        step("frz_run",     1, 1, 1, 4,  4,  0,  0, 1, 0, 0, C_FZ, 0);
        step("frz_w1",      1, 1, 0, 0,  0,  0,  1, 1, 0, 0, C_FZ, 0);
        step("frz_w2",      1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("release_br",  1, 1, 0, 0,  0,  0,  1, 1, 1, 0, C_BR, 0);
        step("back_in_run", 1, 1, 0, 0,  0,  0,  0, 1, 1, 0, C_N,  0);
        step("mw_enter",    1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("mw_reset",    1, 0, 0, 0,  0,  0,  0, 1, 0, 0, C_N,  0);
        step("post_rst",    1, 1, 0, 0,  0,  0,  0, 1, 1, 0, C_N,  0);
        step("to_run",      1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("to_w1",       1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("to_w2",       1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("to_w3",       1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("to_w4",       1, 1, 0, 0,  0,  0,  0, 1, 0, 0, C_FZ, 0);
        step("halt_a",      1, 1, 1, 5,  5,  0,  1, 1, 1, 0, C_HT, 1);
        step("halt_b",      1, 1, 0, 0,  0,  0,  0, 0, 1, 0, C_HT, 1);
        step("halt_clr",    1, 1, 0, 0,  0,  0,  0, 0, 0, 1, C_HT, 1);
        step("halt_rst",    1, 0, 0, 0,  0,  0,  0, 0, 0, 0, C_N,  0);
        step("run_again",   1, 1, 0, 0,  0,  0,  0, 1, 1, 0, C_N,  0);
        step("lu_cnt1",     1, 1, 1, 6,  6,  0,  0, 0, 0, 0, C_LU, 0);
        step("clr_with_lu", 1, 1, 1, 6,  6,  0,  0, 0, 0, 1, C_LU, 0);
        step("after_clr",   1, 1, 0, 0,  0,  0,  0, 0, 0, 0, C_N,  0);
        for (int i = 0; i < 65535; i++)
            step("preload", 0, 1, 1, 5, 0, 5, 0, 0, 0, 0, C_LU, 0);
        step("sat_a",       1, 1, 1, 5,  0,  5,  0, 0, 0, 0, C_LU, 0);
        step("sat_b",       1, 1, 1, 5,  0,  5,  0, 0, 0, 1, C_LU, 0);
        step("sat_clr",     1, 1, 0, 0,  0,  0,  0, 0, 0, 0, C_N,  0);
        @(posedge clk);
        #1;
        chk_vld = 1'b0;
        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
